fifo_skew_bank: RTL
===================

# fifo_skew_bank

Multi-channel parallel-load delay buffer that feeds skewed operand wavefronts into the systolic matrix-multiply array. It holds CHANNELS independent shift registers of DEPTH entries each. A whole tile is written in one cycle. On start, every channel drains to its output, lowest index first. Channel c is delayed by c cycles when skewing is enabled, which produces the diagonal wavefront the array expects. A cycle counter, a small FSM and a busy/done handshake mean the controller no longer has to sequence per-row enables itself.

## Interface
Parameters:
- CHANNELS, 8, number of independent channels (array rows/columns fed)
- DEPTH, 8, entries per channel
- BITS, 8, data width per entry
- SKEW_EN, 1, 1 = channel c delayed c cycles; 0 = all channels drain in lockstep

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- ld  input  1  parallel-load strobe; accepted only when busy=0
- ld_data  input  BITS x [CHANNELS][DEPTH]  tile; ld_data[c][e] is entry e of channel c
- start  input  1  begin drain; accepted only when busy=0 and ld=0
- stall  input  1  freeze drain (counter, shifts, outputs held)
- q  output  BITS x [CHANNELS]  per-channel output word, 0 when not valid
- q_valid  output  CHANNELS  per-channel valid
- busy  output  1  high in DRAIN
- done  output  1  one-cycle pulse after last drain cycle

## Operation
- Storage: regs[c][e]. Reset clears all entries to 0.
- FSM has 2 states, IDLE and DRAIN. It resets to IDLE with counter t=0.
- IDLE, ld=1: regs[c][e] <= ld_data[c][e] for all c, e. State stays IDLE. ld has priority over start, so a start in the same cycle is dropped.
- IDLE, start=1, ld=0: go to DRAIN with t=0.
- L = DEPTH + (SKEW_EN ? CHANNELS-1 : 0) is the drain length. t runs 0..L-1.
- Per-channel offset o_c = SKEW_EN ? c : 0. Channel c is active when o_c <= t < o_c+DEPTH.
- q_valid[c] = (state==DRAIN) && channel c active.
- q[c] = regs[c][0] when q_valid[c], otherwise 0.
- In DRAIN with stall=0:
  - Each active channel shifts regs[c][e] <= regs[c][e+1], and regs[c][DEPTH-1] <= 0.
  - Inactive channels hold.
  - t increments.
- In DRAIN with stall=1: nothing changes and outputs are held.
- At t=L-1 with stall=0: go to IDLE, t <= 0, done pulses high for the next cycle only.
- Any ld or start while busy=1 is ignored.
- Once drained, channels contain 0. A new tile needs a new ld.
- A start with no prior ld drains the current contents: zeros after reset or after a drain.

## Timing
- Reset values: q=0, q_valid=0, busy=0, done=0, state IDLE, t=0, all regs 0.
- Reset asserted mid-drain aborts immediately. No done is issued.
- ld sampled at edge k: data is visible in regs from cycle k+1.
- start sampled at edge k: in cycle k+1, busy=1, t=0, q_valid[0]=1 and q[0]=ld_data[0][0].
- Outputs are combinational from registered state and regs. q is valid in the same cycle as q_valid.
- Channel c emits entry e during the drain cycle with t=o_c+e, counting only non-stalled cycles.
- Drain occupies exactly L unstalled cycles. Each stall cycle adds one cycle.
- done is high exactly one cycle, in the cycle after the last drain cycle. busy=0 in that same cycle.
- ld or start is accepted in the done cycle, so back-to-back tiles lose one cycle: load, then start.

## Test plan
All tests use CHANNELS=4, DEPTH=4, BITS=8.
- Reset then start with no ld, SKEW_EN=1 -> 7 busy cycles; q all 0 throughout; q_valid[0] high for t=0..3 and q_valid[3] high for t=3..6; done pulses in cycle 8 after start.
- ld with ld_data[c][e]=16*c+e, start, SKEW_EN=1 -> at t=3, q={0x30,0x21,0x12,0x03} (ch3..ch0), all q_valid=1; at t=6 only q[3]=0x33 is valid.
- Same tile with SKEW_EN=0 -> L=4; at t=2, q={0x32,0x22,0x12,0x02}, q_valid=4'b1111; done in the next cycle after t=3.
- stall held 2 cycles at t=2 (SKEW_EN=1) -> q and q_valid frozen at t=2 values for 3 cycles; done delayed by 2; output sequence otherwise identical.
- ld with new data and start asserted together while busy, then ld and start in the same cycle while IDLE -> both ignored while busy; the IDLE-cycle ld loads and its start is dropped (busy stays 0).
- rst_n dropped at t=4 mid-drain -> q=0, q_valid=0, busy=0, no done pulse; a following start drains zeros.

Source files
------------

// File: rtl/fifo_skew_bank.sv
// Parallel-load per-channel shift registers drained as a skewed wavefront into a systolic array.
// Outputs are combinational from registered state; stall freezes the drain.
module fifo_skew_bank #(
   parameter int CHANNELS = 8,
   parameter int DEPTH    = 8,
   parameter int BITS     = 8,
   parameter bit SKEW_EN  = 1'b1
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     ld,
   input  logic [CHANNELS-1:0][DEPTH-1:0][BITS-1:0] ld_data,
   input  logic                                     start,
   input  logic                                     stall,
   output logic [CHANNELS-1:0][BITS-1:0]            q,
   output logic [CHANNELS-1:0]                      q_valid,
   output logic                                     busy,
   output logic                                     done
);

   localparam int L  = DEPTH + (SKEW_EN ? CHANNELS - 1 : 0);
   localparam int TW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                                  state, state_nx;
   logic [TW-1:0]                           t, t_nx;
   logic                                    done_nx;
   logic [CHANNELS-1:0]                     active;
   logic [CHANNELS-1:0][DEPTH-1:0][BITS-1:0] regs;

   // Channel c is live for DEPTH counter values starting at its skew offset.
   always_comb begin
      active = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         int oc;
         oc = SKEW_EN ? c : 0;
         active[c] = (32'(t) >= oc) && (32'(t) < oc + DEPTH);
      end
   end

   always_comb begin
      state_nx = state;
      t_nx     = t;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (!ld && start) begin
               state_nx = DRAIN;
               t_nx     = '0;
            end
         end
         DRAIN: begin
            if (!stall) begin
               if (t == TW'(L - 1)) begin
                  state_nx = IDLE;
                  t_nx     = '0;
                  done_nx  = 1'b1;
               end else begin
                  t_nx = t + TW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         t     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         t     <= t_nx;
         done  <= done_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else if (state == IDLE && ld) begin
         regs <= ld_data;
      end else if (state == DRAIN && !stall) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (active[c]) begin
               for (int e = 0; e < DEPTH - 1; e++) regs[c][e] <= regs[c][e+1];
               regs[c][DEPTH-1] <= '0;
            end
         end
      end
   end

   assign busy    = (state == DRAIN);
   assign q_valid = active & {CHANNELS{busy}};

   always_comb begin
      for (int c = 0; c < CHANNELS; c++)
         q[c] = q_valid[c] ? regs[c][0] : '0;
   end

endmodule
